// File: rtl/bus_pkg.sv
// bus_pkg: definitions shared by every block on the 32-bit datapath bus.
//   DATA_W      bus and register width
//   bus_sel_t   5-bit bus source/destination select code
//   SEL_*       select code assignments used by the source mux and the
//               destination register bank
package bus_pkg;

  localparam int DATA_W = 32;

  typedef logic [4:0] bus_sel_t;

  localparam bus_sel_t SEL_R0     = 5'd0;
  localparam bus_sel_t SEL_R1     = 5'd1;
  localparam bus_sel_t SEL_R2     = 5'd2;
  localparam bus_sel_t SEL_R3     = 5'd3;
  localparam bus_sel_t SEL_R4     = 5'd4;
  localparam bus_sel_t SEL_R5     = 5'd5;
  localparam bus_sel_t SEL_R6     = 5'd6;
  localparam bus_sel_t SEL_R7     = 5'd7;
  localparam bus_sel_t SEL_R8     = 5'd8;
  localparam bus_sel_t SEL_R9     = 5'd9;
  localparam bus_sel_t SEL_R10    = 5'd10;
  localparam bus_sel_t SEL_R11    = 5'd11;
  localparam bus_sel_t SEL_R12    = 5'd12;
  localparam bus_sel_t SEL_R13    = 5'd13;
  localparam bus_sel_t SEL_R14    = 5'd14;
  localparam bus_sel_t SEL_R15    = 5'd15;
  localparam bus_sel_t SEL_HI     = 5'd16;
  localparam bus_sel_t SEL_LO     = 5'd17;
  localparam bus_sel_t SEL_ZHI    = 5'd18;
  localparam bus_sel_t SEL_ZLO    = 5'd19;
  localparam bus_sel_t SEL_PC     = 5'd20;
  localparam bus_sel_t SEL_MDR    = 5'd21;
  localparam bus_sel_t SEL_INPORT = 5'd22;
  localparam bus_sel_t SEL_C      = 5'd23;
  localparam bus_sel_t SEL_NONE   = 5'd31;

endpackage

// File: rtl/onehot_encode18.sv
// onehot_encode18: classifies the 18-bit load vector {lo, hi, gp[15:0]}.
//   load_vec  in   load enables; bit position equals the bus select code
//   is_zero   out  no enable set
//   is_one    out  exactly one enable set
//   is_multi  out  two or more enables set
//   index     out  select code of the set bit (valid only when is_one)
module onehot_encode18
  import bus_pkg::*;
(
  input  logic [17:0] load_vec,
  output logic        is_zero,
  output logic        is_one,
  output logic        is_multi,
  output bus_sel_t    index
);

  logic [4:0] count;

  always_comb begin
    count = '0;
    index = SEL_NONE;
    for (int i = 0; i < 18; i++) begin
      if (load_vec[i]) begin
        count = count + 5'd1;
        index = bus_sel_t'(i);
      end
    end
    is_zero  = (count == 5'd0);
    is_one   = (count == 5'd1);
    is_multi = (count >= 5'd2);
  end

endmodule

// File: rtl/bus_dest_regs.sv
// bus_dest_regs: destination side of the datapath bus. Captures bus_in into
// R0..R15, HI or LO under one-hot load enables and drives the stored values
// back to the source mux.
//   clock, clear          rising-edge clock, async active-high reset
//   bus_in                value to capture
//   gp_in, hi_in, lo_in   one-hot load enables
//   ba_out                forces the R0 output slice to zero (storage unaffected)
//   gp_q, hi_q, lo_q      register contents (Rk at gp_q[k*DATA_W +: DATA_W])
//   wr_ack                pulse the cycle after a legal single write
//   last_dest             select code of the last legal write (SEL_NONE after reset)
//   multi_err             sticky: several enables seen in one cycle
// Optional: BUS_DEST_WRCOUNT_EN adds wr_count, a saturating 16-bit count of
// legal writes.
module bus_dest_regs #(
  parameter int DATA_W = bus_pkg::DATA_W,
  parameter int NUM_GP = 16
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        bus_in,
  input  logic [NUM_GP-1:0]        gp_in,
  input  logic                     hi_in,
  input  logic                     lo_in,
  input  logic                     ba_out,
  output logic [NUM_GP*DATA_W-1:0] gp_q,
  output logic [DATA_W-1:0]        hi_q,
  output logic [DATA_W-1:0]        lo_q,
  output logic                     wr_ack,
  output logic [4:0]               last_dest,
  output logic                     multi_err
`ifdef BUS_DEST_WRCOUNT_EN
  , output logic [15:0]            wr_count
`endif
);

  import bus_pkg::*;

  // The select encoding only has room for sixteen general registers.
  if (NUM_GP != 16) begin : g_num_gp_check
    $error("bus_dest_regs: NUM_GP must be 16");
  end

  logic [17:0] load_vec;
  logic        is_zero, is_one, is_multi;
  bus_sel_t    load_idx;

  assign load_vec = {lo_in, hi_in, gp_in};

  onehot_encode18 u_enc (
    .load_vec (load_vec),
    .is_zero  (is_zero),
    .is_one   (is_one),
    .is_multi (is_multi),
    .index    (load_idx)
  );

  logic [DATA_W-1:0] gp_regs_q [NUM_GP];
  logic [DATA_W-1:0] gp_regs_d [NUM_GP];
  logic [DATA_W-1:0] hi_d, lo_d;
  logic              wr_ack_q, wr_ack_d;
  bus_sel_t          last_dest_q, last_dest_d;
  logic              multi_err_q, multi_err_d;

  always_comb begin
    gp_regs_d   = gp_regs_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    wr_ack_d    = is_one;
    last_dest_d = last_dest_q;
    multi_err_d = multi_err_q | is_multi;
    // Only a single enable commits; conflicting enables leave everything alone.
    if (is_one) begin
      last_dest_d = load_idx;
      for (int k = 0; k < NUM_GP; k++) begin
        if (gp_in[k]) gp_regs_d[k] = bus_in;
      end
      if (hi_in) hi_d = bus_in;
      if (lo_in) lo_d = bus_in;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int k = 0; k < NUM_GP; k++) gp_regs_q[k] <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      wr_ack_q    <= 1'b0;
      last_dest_q <= SEL_NONE;
      multi_err_q <= 1'b0;
    end else begin
      gp_regs_q   <= gp_regs_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      wr_ack_q    <= wr_ack_d;
      last_dest_q <= last_dest_d;
      multi_err_q <= multi_err_d;
    end
  end

  // R0 doubles as a base register; ba_out masks it on the way out only.
  for (genvar k = 0; k < NUM_GP; k++) begin : g_gp_out
    if (k == 0) begin : g_r0
      assign gp_q[k*DATA_W +: DATA_W] = gp_regs_q[k] & {DATA_W{~ba_out}};
    end else begin : g_rk
      assign gp_q[k*DATA_W +: DATA_W] = gp_regs_q[k];
    end
  end

  assign wr_ack    = wr_ack_q;
  assign last_dest = last_dest_q;
  assign multi_err = multi_err_q;

`ifdef BUS_DEST_WRCOUNT_EN
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (is_one && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) wr_count_q <= '0;
    else       wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

  logic unused_zero;
  assign unused_zero = is_zero;

endmodule

// File: tb/tb_bus_dest_regs.sv
module tb_bus_dest_regs;

  localparam int DW = 32;
  localparam int NG = 16;

  logic             clock = 1'b0;
  logic             clear;
  logic [DW-1:0]    bus_in;
  logic [NG-1:0]    gp_in;
  logic             hi_in, lo_in, ba_out;
  logic [NG*DW-1:0] gp_q;
  logic [DW-1:0]    hi_q, lo_q;
  logic             wr_ack;
  logic [4:0]       last_dest;
  logic             multi_err;
`ifdef BUS_DEST_WRCOUNT_EN
  logic [15:0]      wr_count;
`endif

  bus_dest_regs dut (
    .clock     (clock),
    .clear     (clear),
    .bus_in    (bus_in),
    .gp_in     (gp_in),
    .hi_in     (hi_in),
    .lo_in     (lo_in),
    .ba_out    (ba_out),
    .gp_q      (gp_q),
    .hi_q      (hi_q),
    .lo_q      (lo_q),
    .wr_ack    (wr_ack),
    .last_dest (last_dest),
    .multi_err (multi_err)
`ifdef BUS_DEST_WRCOUNT_EN
    , .wr_count (wr_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NG-1:0][DW-1:0] gp;
    logic [DW-1:0]         hi;
    logic [DW-1:0]         lo;
    logic                  ack;
    logic [4:0]            last;
    logic                  merr;
    logic [15:0]           cnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    logic [DW-1:0] r;
    for (int k = 0; k < NG; k++) begin
      r = e.gp[k];
      if (k == 0 && ba_out) r = '0;
      chk($sformatf("%s.R%0d", tag, k), gp_q[k*DW +: DW], r);
    end
    chk({tag, ".hi"}, hi_q, e.hi);
    chk({tag, ".lo"}, lo_q, e.lo);
    chk({tag, ".wr_ack"}, {31'd0, wr_ack}, {31'd0, e.ack});
    chk({tag, ".last_dest"}, {27'd0, last_dest}, {27'd0, e.last});
    chk({tag, ".multi_err"}, {31'd0, multi_err}, {31'd0, e.merr});
`ifdef BUS_DEST_WRCOUNT_EN
    chk({tag, ".wr_count"}, {16'd0, wr_count}, {16'd0, e.cnt});
`endif
  endtask

  task automatic model_reset();
    m      = '0;
    m.last = 5'd31;
  endtask

  // Drive one cycle of loads, predict the post-edge state, compare after the edge.
  task automatic step(input string tag, input logic [DW-1:0] b, input logic [NG-1:0] g,
                      input logic h, input logic l);
    logic [17:0] lv;
    int          n;
    exp_t        e;
    bus_in = b; gp_in = g; hi_in = h; lo_in = l;
    lv = {l, h, g};
    n  = $countones(lv);
    if (n == 1) begin
      for (int i = 0; i < 18; i++) if (lv[i]) m.last = 5'(i);
      for (int k = 0; k < NG; k++) if (g[k]) m.gp[k] = b;
      if (h) m.hi = b;
      if (l) m.lo = b;
      m.ack = 1'b1;
      if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
    end else begin
      m.ack = 1'b0;
      if (n >= 2) m.merr = 1'b1;
    end
    sb.push_back(m);
    @(posedge clock);
    #1;
    bus_in = '0; gp_in = '0; hi_in = 1'b0; lo_in = 1'b0;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_state(tag, e);
    end
  endtask

  // Assert clear away from the clock edge; state must drop before any edge.
  task automatic do_clear(input string tag);
    #2;
    clear = 1'b1;
    model_reset();
    #1;
    check_state({tag, ".async"}, m);
    @(posedge clock);
    #1;
    check_state({tag, ".held"}, m);
    clear = 1'b0;
    bus_in = '0; gp_in = '0; hi_in = 1'b0; lo_in = 1'b0;
  endtask

  initial begin
    clear = 1'b0; bus_in = '0; gp_in = '0; hi_in = 1'b0; lo_in = 1'b0; ba_out = 1'b0;
    model_reset();

    // reset then idle
    do_clear("reset");
    step("idle0", 32'hCAFEF00D, 16'h0000, 1'b0, 1'b0);
    step("idle1", 32'h0, 16'h0000, 1'b0, 1'b0);

    // single write to R5, then ack drops
    step("wr_r5", 32'hDEADBEEF, 16'h0020, 1'b0, 1'b0);
    step("after_r5", 32'h0, 16'h0000, 1'b0, 1'b0);

    // HI then LO back to back
    step("wr_hi", 32'h1, 16'h0000, 1'b1, 1'b0);
    step("wr_lo", 32'h2, 16'h0000, 1'b0, 1'b1);
    step("after_lo", 32'h0, 16'h0000, 1'b0, 1'b0);

    // boundary registers R15, same register twice, back-to-back
    step("wr_r15", 32'hA5A5_5A5A, 16'h8000, 1'b0, 1'b0);
    step("wr_r7a", 32'h0000_0007, 16'h0080, 1'b0, 1'b0);
    step("wr_r7b", 32'h7777_7777, 16'h0080, 1'b0, 1'b0);

    // conflicts: two GP enables, then GP plus HI
    step("conf_gp", 32'hFFFFFFFF, 16'h0003, 1'b0, 1'b0);
    step("conf_hi", 32'hFFFFFFFF, 16'h0100, 1'b1, 1'b0);
    step("conf_hl", 32'hFFFFFFFF, 16'h0000, 1'b1, 1'b1);
    step("wr_r2", 32'h0000_2222, 16'h0004, 1'b0, 1'b0);
    step("after_r2", 32'h0, 16'h0000, 1'b0, 1'b0);

    // ba_out gating of R0, including a write while gated
    step("wr_r0", 32'h0000_1234, 16'h0001, 1'b0, 1'b0);
    ba_out = 1'b1;
    #1;
    chk("ba_on.R0", gp_q[DW-1:0], 32'h0);
    step("wr_r0_ba", 32'h0000_5678, 16'h0001, 1'b0, 1'b0);
    ba_out = 1'b0;
    #1;
    chk("ba_off.R0", gp_q[DW-1:0], 32'h0000_5678);
    step("wr_r0b", 32'h0000_1234, 16'h0001, 1'b0, 1'b0);

    // clear coinciding with a load loses the load
    bus_in = 32'h5555_5555; gp_in = 16'h0400;
    do_clear("mid_clear");
    step("post_clear", 32'h0, 16'h0000, 1'b0, 1'b0);

`ifdef BUS_DEST_WRCOUNT_EN
    step("cnt_w1", 32'h11, 16'h0002, 1'b0, 1'b0);
    step("cnt_w2", 32'h22, 16'h0000, 1'b1, 1'b0);
    step("cnt_conf", 32'h33, 16'h0006, 1'b0, 1'b0);
    step("cnt_w3", 32'h44, 16'h0000, 1'b0, 1'b1);
    chk("cnt_three", {16'd0, wr_count}, 32'd3);
    #2;
    force dut.wr_count_q = 16'hFFFF;
    #1;
    release dut.wr_count_q;
    m.cnt = 16'hFFFF;
    step("cnt_sat", 32'h55, 16'h0008, 1'b0, 1'b0);
`endif

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
